// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin arbitration of the register-file write port
// plus a per-register pending scoreboard that drives the decode RAW stall.
module regfile_wb_sched #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  input  logic                      issue_en,
  input  logic [ADDR_W-1:0]         issue_addr,
  input  logic [ADDR_W-1:0]         raddr1,
  input  logic [ADDR_W-1:0]         raddr2,
  input  logic                      re1,
  input  logic                      re2,
  output logic                      stall
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned NREG  = 1 << ADDR_W;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gidx;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [NUM_REQ-1:0] grant;
  logic              xfer;
  logic [ADDR_W-1:0] gaddr;
  logic [DATA_W-1:0] gdata;
  logic [NREG-1:0]   pending;
  logic              hz1;
  logic              hz2;

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    int unsigned    sum;
    logic [PTR_W-1:0] idx;
    grant = '0;
    gidx  = '0;
    xfer  = 1'b0;
    gaddr = '0;
    gdata = '0;
    sum   = 0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = 32'(rr_ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (!xfer && req_valid[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        xfer       = 1'b1;
        gaddr      = addr_a[idx];
        gdata      = data_a[idx];
      end
    end
    if (rst) begin
      grant = '0;
      xfer  = 1'b0;
    end
  end

  assign req_ready = grant;
  assign nxt_ptr   = (32'(gidx) == NUM_REQ - 1) ? '0 : gidx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      rr_ptr  <= '0;
      pending <= '0;
    end else begin
      we <= xfer && (gaddr != '0);
      if (xfer) begin
        waddr  <= gaddr;
        wdata  <= gdata;
        rr_ptr <= nxt_ptr;
      end
      // Set is applied after clear so a newer producer stays outstanding.
      if (we) pending[waddr] <= 1'b0;
      if (issue_en && (issue_addr != '0)) pending[issue_addr] <= 1'b1;
    end
  end

  // The register file forwards same-cycle writes, so a committing write masks the hazard.
  assign hz1   = re1 && (raddr1 != '0) && pending[raddr1] && !(we && (waddr == raddr1));
  assign hz2   = re2 && (raddr2 != '0) && pending[raddr2] && !(we && (waddr == raddr2));
  assign stall = !rst && (hz1 || hz2);

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: expected writes are queued at grant time
// and a negedge monitor compares them against the registered write port.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        re1;
  logic        re2;
  logic        stall;

  logic [4:0]  ra [3];
  logic [31:0] rd [3];

  assign req_addr = {ra[2], ra[1], ra[0]};
  assign req_data = {rd[2], rd[1], rd[0]};

  regfile_wb_sched #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .raddr1(raddr1), .raddr2(raddr2), .re1(re1), .re2(re2),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every committed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_en && we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected: got we=1 waddr=%0d wdata=%h, required no write", waddr, wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.addr != waddr || e.data != wdata) begin
          bad++;
          $display("FAIL write_port: got cyc=%0d waddr=%0d wdata=%h, required cyc=%0d waddr=%0d wdata=%h",
                   cyc, waddr, wdata, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  int unsigned gcnt [3];

  initial begin
    rst = 1'b1; req_valid = '0; issue_en = 1'b0; issue_addr = '0;
    raddr1 = '0; raddr2 = '0; re1 = 1'b0; re2 = 1'b0;
    for (int i = 0; i < 3; i++) begin ra[i] = '0; rd[i] = '0; gcnt[i] = 0; end

    // Reset: ready and stall forced low while rst is high.
    next_cyc();
    mon_en = 1'b1;
    req_valid = 3'b111; re1 = 1'b1; raddr1 = 5'd3;
    #2;
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    chk("stall_in_reset", 64'(stall), 64'd0);
    next_cyc();
    req_valid = '0; re1 = 1'b0; rst = 1'b0;
    #2;
    chk("reset_we", 64'(we), 64'd0);
    chk("reset_waddr", 64'(waddr), 64'd0);
    chk("reset_wdata", 64'(wdata), 64'd0);
    chk("idle_ready", 64'(req_ready), 64'd0);

    // Contention: grant order 0,1,2,0,1,2.
    for (int c = 0; c < 6; c++) begin
      int g;
      next_cyc();
      g = c % 3;
      req_valid = 3'b111;
      for (int i = 0; i < 3; i++) begin
        ra[i] = 5'(10 + i);
        rd[i] = 32'hA000_0000 | (32'(i) << 8) | gcnt[i];
      end
      #2;
      chk($sformatf("contend_grant_%0d", c), 64'(req_ready), 64'(3'b001 << g));
      expect_write(ra[g], rd[g]);
      gcnt[g]++;
    end

    // Single request from requester 1.
    next_cyc();
    req_valid = 3'b010; ra[1] = 5'd5; rd[1] = 32'hDEADBEEF;
    #2;
    chk("single_ready", 64'(req_ready), 64'(3'b010));
    expect_write(5'd5, 32'hDEADBEEF);

    // x0 write: accepted but no write enable.
    next_cyc();
    req_valid = 3'b001; ra[0] = 5'd0; rd[0] = 32'h1234_5678;
    #2;
    chk("x0_ready", 64'(req_ready), 64'(3'b001));
    next_cyc();
    req_valid = '0; re1 = 1'b1; raddr1 = 5'd5;
    #2;
    chk("x0_no_we", 64'(we), 64'd0);
    chk("x0_no_pending", 64'(stall), 64'd0);

    // RAW stall on x7, cleared by requester 2's write-back.
    next_cyc();
    re1 = 1'b0; issue_en = 1'b1; issue_addr = 5'd7;
    next_cyc();
    issue_en = 1'b0; re1 = 1'b1; raddr1 = 5'd7;
    #2;
    chk("raw_stall_set", 64'(stall), 64'd1);
    next_cyc();
    req_valid = 3'b100; ra[2] = 5'd7; rd[2] = 32'h0000_0077;
    #2;
    chk("raw_stall_hold", 64'(stall), 64'd1);
    chk("raw_ready", 64'(req_ready), 64'(3'b100));
    expect_write(5'd7, 32'h0000_0077);
    next_cyc();
    req_valid = '0;
    #2;
    chk("raw_forward_nostall", 64'(stall), 64'd0);
    next_cyc();
    #2;
    chk("raw_cleared", 64'(stall), 64'd0);

    // Set/clear collision on x9: set wins.
    next_cyc();
    re1 = 1'b0;
    req_valid = 3'b001; ra[0] = 5'd9; rd[0] = 32'h0000_0099;
    #2;
    chk("coll_ready", 64'(req_ready), 64'(3'b001));
    expect_write(5'd9, 32'h0000_0099);
    next_cyc();
    req_valid = '0; issue_en = 1'b1; issue_addr = 5'd9;
    next_cyc();
    issue_en = 1'b0; re2 = 1'b1; raddr2 = 5'd9;
    #2;
    chk("coll_stall", 64'(stall), 64'd1);

    // Reset mid-stream with a write in flight and x9 pending.
    next_cyc();
    req_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin ra[i] = 5'(20 + i); rd[i] = 32'hC000_0000 + 32'(i); end
    #2;
    chk("pre_reset_ready", 64'(req_ready), 64'(3'b010));
    expect_write(5'd21, 32'hC000_0001);
    next_cyc();
    rst = 1'b1;
    #2;
    chk("mid_reset_ready", 64'(req_ready), 64'd0);
    chk("mid_reset_stall", 64'(stall), 64'd0);
    next_cyc();
    rst = 1'b0;
    #2;
    chk("post_reset_we", 64'(we), 64'd0);
    chk("post_reset_stall", 64'(stall), 64'd0);
    chk("post_reset_grant0", 64'(req_ready), 64'(3'b001));
    expect_write(5'd20, 32'hC000_0000);
    next_cyc();
    req_valid = '0; re2 = 1'b0;

    repeat (3) next_cyc();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the 32×32 integer register file. It arbitrates the register file's single write port among several write-back requesters using a round-robin policy and drives a registered write port. It also keeps a per-register pending scoreboard so the decode stage can stall on read-after-write hazards. It sits between the EX/MEM/LSU result sources and the register file, and beside the decode stage.

## Interface
Parameters:
- NUM_REQ, 3, number of write-back requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

Ports:
- clk  in  1  clock; everything is updated on its rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a result to write
- req_addr  in  NUM_REQ*ADDR_W  destination of requester i, in slice i
- req_data  in  NUM_REQ*DATA_W  result of requester i, in slice i
- req_ready  out  NUM_REQ  one-hot grant; requester i's result is accepted this cycle
- we  out  1  register-file write enable (registered)
- waddr  out  ADDR_W  register-file write address (registered)
- wdata  out  DATA_W  register-file write data (registered)
- issue_en  in  1  decode issues an instruction that will write issue_addr
- issue_addr  in  ADDR_W  destination register of the issued instruction
- raddr1, raddr2  in  ADDR_W  decode read addresses
- re1, re2  in  1  decode read enables
- stall  out  1  decode must hold; a source register is pending

## Operation
- Arbitration:
  - req_ready is combinational from req_valid and the round-robin pointer rr_ptr.
  - The search starts at rr_ptr and wraps modulo NUM_REQ. The first valid requester is granted.
  - At most one requester is granted per cycle. req_ready is all-zero when no requester is valid.
- Round-robin pointer: on a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid, addr and data stable until it is granted. It may drop valid only after the transfer.
  - The scheduler never deasserts ready for a requester that is valid and selected.
- Write port, on each edge:
  - we <= transfer && granted addr != 0.
  - waddr and wdata <= the granted slice when a transfer occurs; otherwise they hold their previous values.
  - A write to x0 is accepted (ready is asserted) but produces we=0.
- Scoreboard (pending[31:1]; x0 is never pending):
  - set: issue_en && issue_addr != 0 → pending[issue_addr] <= 1.
  - clear: we=1 (the register file commits this cycle) → pending[waddr] <= 0.
  - When set and clear hit the same address in the same cycle, set wins; the newer producer is outstanding.
- Stall, combinational:
  - hz_k = re_k && raddr_k != 0 && pending[raddr_k] && !(we && waddr == raddr_k), for k = 1, 2.
  - stall = hz1 | hz2.
  - The we/waddr term exists because the register file forwards wdata to a same-cycle read, so no stall is needed in that case.
- Exactly one write-back per issued destination is expected. Write-backs to an address that is not pending clear nothing else and raise no error.

## Timing
- Grant to register-file write: one cycle. A transfer at edge N drives we/waddr/wdata during cycle N+1, and the register file writes at edge N+1.
- Throughput: one write per cycle sustained. Under continuous contention each requester is granted at least once every NUM_REQ cycles.
- Scoreboard set takes effect at the edge following issue_en. stall sees the new pending bit in the next cycle.
- Reset (rst=1 at an edge):
  - we=0, waddr=0, wdata=0, rr_ptr=0, all pending=0.
  - req_ready and stall are 0 while rst=1, regardless of inputs.
- Reset asserted mid-operation: in-flight write data in the output register is discarded and the pending bits are lost. Requesters must also be reset.

## Test plan
- Single request: req_valid=3'b010, req_addr[1]=5, req_data[1]=0xDEADBEEF → req_ready=3'b010 that cycle; next cycle we=1, waddr=5, wdata=0xDEADBEEF.
- Contention: all three valid for 6 cycles from reset → grant order 0,1,2,0,1,2; we=1 every cycle after the first.
- x0 write: requester 0 valid with addr=0 → ready=3'b001; next cycle we=0; no pending bit changes.
- RAW stall: issue_en with issue_addr=7; next cycle re1=1, raddr1=7 → stall=1. Requester 2 then writes x7 → in the cycle we=1/waddr=7, stall=0, and pending[7]=0 afterwards.
- Set/clear collision: issue_en/issue_addr=9 in the same cycle as we=1/waddr=9 → pending[9]=1 after the edge; raddr2=9, re2=1 → stall=1.
- Reset mid-stream: rst=1 for one cycle while requests and pending bits are active → next cycle we=0, stall=0, and the following grant starts at requester 0.
